dfa_rom_arbiter: RTL and testbench

//  Shares one rom_shared DFA transition ROM between NUM_REQ per-core CAM monitors.

---
 rtl/dfa_rom_arbiter.sv | 151 +++++++++++++++
 tb/tb_dfa_rom_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/dfa_rom_arbiter.sv
// dfa_rom_arbiter: round-robin share of one DFA transition ROM among NUM_REQ CAM monitors.
// A tag pipeline follows every read so the ROM word is routed back to the requester that
// issued it; a flush drops that requester's in-flight reads.
// Build option: define DFA_ARB_DUAL_PORT_EN to grant a second requester per cycle on ROM port B.
module dfa_rom_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int AW      = 12,
   parameter int DW      = 32,
   parameter int ROM_LAT = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [NUM_REQ*AW-1:0] req_addr,
   input  logic [NUM_REQ-1:0]    flush,
   output logic [NUM_REQ-1:0]    gnt,
   output logic [NUM_REQ-1:0]    rsp_valid,
   output logic [NUM_REQ*DW-1:0] rsp_data,
   output logic [AW-1:0]         rom_addr_a,
   output logic                  rom_rden_a,
   input  logic [DW-1:0]         rom_q_a,
   output logic [AW-1:0]         rom_addr_b,
   output logic                  rom_rden_b,
   input  logic [DW-1:0]         rom_q_b
);
   localparam int IW = $clog2(NUM_REQ);
`ifdef DFA_ARB_DUAL_PORT_EN
   localparam int NP = 2;
`else
   localparam int NP = 1;
`endif
   logic [AW-1:0]      addr_arr [NUM_REQ];
   logic [NUM_REQ-1:0] elig, gnt_nxt, rsp_hit;
   logic [DW-1:0]      hit_q [NUM_REQ];
   logic [IW-1:0]      rr_ptr, rr_nxt, last_id;
   logic [IW:0]        idx;
   logic               taken;
   logic [NP-1:0]      win_v, port_rden;
   logic [IW-1:0]      win_id [NP];
   logic [AW-1:0]      win_addr [NP];
   logic [AW-1:0]      port_addr [NP];
   logic [DW-1:0]      port_q [NP];
   logic [ROM_LAT-1:0] tag_v [NP];
   logic [IW-1:0]      tag_id [NP][ROM_LAT];

   assign elig = req & ~gnt & ~flush;

   // split the packed address bus into per-requester words
   always_comb
      for (int i = 0; i < NUM_REQ; i++) addr_arr[i] = req_addr[i*AW +: AW];

   // scan eligible requesters in wrap order from rr_ptr; first hit takes port A, next hit port B
   always_comb begin
      win_v = '0;
      gnt_nxt = '0;
      idx = '0;
      taken = 1'b0;
      for (int p = 0; p < NP; p++) begin
         win_id[p] = '0;
         win_addr[p] = '0;
      end
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = {1'b0, rr_ptr} + (IW+1)'(k);
         if (idx >= (IW+1)'(NUM_REQ)) idx = idx - (IW+1)'(NUM_REQ);
         taken = 1'b0;
         for (int p = 0; p < NP; p++)
            if (elig[idx[IW-1:0]] && !taken && !win_v[p]) begin
               win_v[p] = 1'b1;
               win_id[p] = idx[IW-1:0];
               win_addr[p] = addr_arr[idx[IW-1:0]];
               gnt_nxt[idx[IW-1:0]] = 1'b1;
               taken = 1'b1;
            end
      end
   end

   assign last_id = win_v[NP-1] ? win_id[NP-1] : win_id[0];
   assign rr_nxt  = (last_id == IW'(NUM_REQ-1)) ? '0 : last_id + 1'b1;

   // register grants and move the round-robin pointer past the last winner
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gnt <= '0;
         rr_ptr <= '0;
      end else begin
         gnt <= gnt_nxt;
         if (win_v[0]) rr_ptr <= rr_nxt;
      end
   end

   // drive the ROM ports and shift owner tags alongside the ROM latency, dropping flushed owners
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         port_rden <= '0;
         for (int p = 0; p < NP; p++) begin
            port_addr[p] <= '0;
            tag_v[p] <= '0;
            for (int s = 0; s < ROM_LAT; s++) tag_id[p][s] <= '0;
         end
      end else begin
         port_rden <= win_v;
         for (int p = 0; p < NP; p++) begin
            if (win_v[p]) port_addr[p] <= win_addr[p];
            tag_v[p][0] <= win_v[p];
            tag_id[p][0] <= win_id[p];
            for (int s = 1; s < ROM_LAT; s++) begin
               tag_v[p][s] <= tag_v[p][s-1] & ~flush[tag_id[p][s-1]];
               tag_id[p][s] <= tag_id[p][s-1];
            end
         end
      end
   end

   // route each exiting tag's ROM word to its owner; a flush in the exit cycle suppresses it
   always_comb begin
      rsp_hit = '0;
      for (int i = 0; i < NUM_REQ; i++) hit_q[i] = '0;
      for (int p = 0; p < NP; p++)
         for (int i = 0; i < NUM_REQ; i++)
            if (tag_v[p][ROM_LAT-1] && tag_id[p][ROM_LAT-1] == IW'(i) && !flush[i]) begin
               rsp_hit[i] = 1'b1;
               hit_q[i] = port_q[p];
            end
   end

   // register response pulses; read data holds until the owner's next response
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_valid <= '0;
         rsp_data <= '0;
      end else begin
         rsp_valid <= rsp_hit;
         for (int i = 0; i < NUM_REQ; i++)
            if (rsp_hit[i]) rsp_data[i*DW +: DW] <= hit_q[i];
      end
   end

   assign rom_addr_a = port_addr[0];
   assign rom_rden_a = port_rden[0];
   assign port_q[0]  = rom_q_a;
`ifdef DFA_ARB_DUAL_PORT_EN
   assign rom_addr_b = port_addr[1];
   assign rom_rden_b = port_rden[1];
   assign port_q[1]  = rom_q_b;
`else
   logic unused_q_b;
   assign rom_addr_b = '0;
   assign rom_rden_b = 1'b0;
   assign unused_q_b = ^rom_q_b;
`endif
endmodule

// File: tb/tb_dfa_rom_arbiter.sv
// tb_dfa_rom_arbiter: directed bench with a response scoreboard for dfa_rom_arbiter.
module tb_dfa_rom_arbiter;
   localparam int NR = 4, AW = 12, DW = 32, LAT = 2;

   logic clk = 1'b0, reset = 1'b1;
   logic [NR-1:0] req = '0, flush = '0;
   logic [AW-1:0] addr [NR];
   logic [NR*AW-1:0] req_addr;
   logic [NR-1:0] gnt, rsp_valid;
   logic [NR*DW-1:0] rsp_data;
   logic [AW-1:0] rom_addr_a, rom_addr_b;
   logic rom_rden_a, rom_rden_b;
   logic [DW-1:0] rom_q_a = '0, rom_q_b = '0;

   typedef struct { int id; logic [DW-1:0] data; int cyc; } exp_t;
   exp_t exp_q[$];
   int n_chk = 0, n_fail = 0, cyc = 0;

   assign req_addr = {addr[3], addr[2], addr[1], addr[0]};

   dfa_rom_arbiter #(.NUM_REQ(NR), .AW(AW), .DW(DW), .ROM_LAT(LAT)) dut (
      .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .flush(flush),
      .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .rom_addr_a(rom_addr_a), .rom_rden_a(rom_rden_a), .rom_q_a(rom_q_a),
      .rom_addr_b(rom_addr_b), .rom_rden_b(rom_rden_b), .rom_q_b(rom_q_b)
   );

   function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
      return {4'hd, a, ~a, 4'h5};
   endfunction

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // ROM model: output register behind the DUT's address register gives two cycles total
   always @(posedge clk) begin
      rom_q_a <= rom_f(rom_addr_a);
      rom_q_b <= rom_f(rom_addr_b);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_rsp(input int id, input logic [AW-1:0] a);
      exp_t e;
      e.id = id;
      e.data = rom_f(a);
      e.cyc = cyc + LAT + 1;
      exp_q.push_back(e);
   endtask

   // monitor: pop and compare whenever the DUT presents a response, flag overdue expectations
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         for (int i = 0; i < NR; i++)
            if (rsp_valid[i]) begin
               if (exp_q.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL rsp_unexpected: requester %0d rsp_valid at cycle %0d, required none", i, cyc);
               end else begin
                  e = exp_q.pop_front();
                  check("rsp_owner", i, e.id);
                  check("rsp_data", rsp_data[i*DW +: DW], e.data);
                  check("rsp_cycle", cyc, e.cyc);
               end
            end
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            n_chk++;
            n_fail++;
            $display("FAIL rsp_missing: requester %0d no response by cycle %0d, required at %0d",
                     exp_q[0].id, cyc, exp_q[0].cyc);
            void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      addr[0] = 12'h100;
      addr[1] = 12'h2a7;
      addr[2] = 12'h3b5;
      addr[3] = 12'hfff;
      repeat (2) step();
      check("rst_gnt", gnt, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rden_a", rom_rden_a, 0);
      check("rst_addr_a", rom_addr_a, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_rden_b", rom_rden_b, 0);
      check("rst_addr_b", rom_addr_b, 0);
      reset = 1'b0;
      step();

      // only requester 3 with rr_ptr 0: wrap search picks 3
      req = 4'b1000;
      expect_rsp(3, addr[3]);
      step();
      check("wrap_gnt", gnt, 4'b1000);
      check("wrap_addr", rom_addr_a, 12'hfff);
      req = '0;
      step();
      check("wrap_gnt_pulse", gnt, 0);
      repeat (4) step();

`ifndef DFA_ARB_DUAL_PORT_EN
      // all requesting: grants rotate one per cycle starting at 0
      req = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         expect_rsp(k % 4, addr[k % 4]);
         step();
         check("rotate_gnt", gnt, 64'(1) << (k % 4));
         check("rotate_addr", rom_addr_a, addr[k % 4]);
         check("rotate_rden_b", rom_rden_b, 0);
      end
      req = '0;
      repeat (5) step();
`endif

      // flush blocks a grant in the same cycle; the request is granted once flush drops
      req = 4'b0100;
      flush = 4'b0100;
      step();
      check("flush_blocks_gnt", gnt, 0);
      check("flush_blocks_rden", rom_rden_a, 0);
      flush = '0;
      expect_rsp(2, addr[2]);
      step();
      check("single_gnt", gnt, 4'b0100);
      check("single_addr", rom_addr_a, 12'h3b5);
      check("single_rden", rom_rden_a, 1);
      req = '0;
      step();
      check("single_gnt_pulse", gnt, 0);
      check("single_rden_low", rom_rden_a, 0);
      check("single_addr_hold", rom_addr_a, 12'h3b5);
      repeat (4) step();
      check("rsp_data_hold2", rsp_data[2*DW +: DW], rom_f(12'h3b5));

`ifndef DFA_ARB_DUAL_PORT_EN
      // requester 1 read flushed in its exit cycle; requester 0 response unaffected
      addr[1] = 12'h055;
      req = 4'b0011;
      expect_rsp(0, addr[0]);
      step();
      check("flush_t_gnt0", gnt, 4'b0001);
      req = 4'b0010;
      step();
      check("flush_t_gnt1", gnt, 4'b0010);
      check("flush_t_addr1", rom_addr_a, 12'h055);
      req = '0;
      step();
      flush = 4'b0010;
      step();
      flush = '0;
      repeat (4) step();
      check("flushed_data_held", rsp_data[1*DW +: DW], rom_f(12'h2a7));
      addr[1] = 12'h2a7;
`endif

      // reset with two reads in flight
      req = 4'b0011;
      step();
      req = 4'b0010;
      step();
      req = '0;
      reset = 1'b1;
      step();
      check("midrst_gnt", gnt, 0);
      check("midrst_rsp_valid", rsp_valid, 0);
      check("midrst_rden_a", rom_rden_a, 0);
      check("midrst_addr_a", rom_addr_a, 0);
      check("midrst_rsp_data", rsp_data, 0);
      step();
      reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         check("post_rst_no_rsp", rsp_valid, 0);
      end

`ifdef DFA_ARB_DUAL_PORT_EN
      // dual port: set rr_ptr to 1, then req 0101 grants 2 on A and 0 on B together
      req = 4'b0001;
      expect_rsp(0, addr[0]);
      step();
      check("dp_pre_gnt", gnt, 4'b0001);
      req = '0;
      step();
      req = 4'b0101;
      expect_rsp(0, addr[0]);
      expect_rsp(2, addr[2]);
      step();
      check("dp_gnt", gnt, 4'b0101);
      check("dp_addr_a", rom_addr_a, addr[2]);
      check("dp_addr_b", rom_addr_b, addr[0]);
      check("dp_rden_b", rom_rden_b, 1);
      check("dp_rr_ptr", dut.rr_ptr, 1);
      req = '0;
      repeat (5) step();
`endif

      repeat (3) step();
      check("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
